// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing from a 100 MHz board clock.
// Produces the pixel enable, raster counters, visible-window flag, active-low
// syncs and a registered RGB stage aligned with the syncs, plus a one-clk
// end-of-frame tick for slow game logic.
// Optional build macro TEST_PATTERN_EN adds an eight-bar colour test pattern
// selected at run time by test_mode; without it test_mode is ignored.
module vga_timing_gen #(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_START = 144,
  parameter int unsigned H_END   = 783,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_START = 35,
  parameter int unsigned V_END   = 514,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  input  logic        test_mode,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_V  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_V  = 10'(V_SYNC);
  localparam logic [9:0] H_START_V = 10'(H_START);
  localparam logic [9:0] H_END_V   = 10'(H_END);
  localparam logic [9:0] V_START_V = 10'(V_START);
  localparam logic [9:0] V_END_V   = 10'(V_END);

  logic [DIV_W-1:0] div_r;
  logic             pix_en_r;
  logic [9:0]       h_r;
  logic [9:0]       v_r;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             bright_r;
  logic             hsync_r;
  logic             vsync_r;
  logic [11:0]      rgb_r;
  logic             frame_tick_r;
  logic [11:0]      pix_src_s;

  // True when the raster position lies inside the visible window.
  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    in_window = (h >= H_START_V) && (h <= H_END_V) &&
                (v >= V_START_V) && (v <= V_END_V);
  endfunction

`ifdef TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'((H_END - H_START + 1) / 8);

  // Colour of the vertical bar covering column h (white first, black last).
  function automatic logic [11:0] bar_colour(input logic [9:0] h);
    logic [9:0] idx;
    idx = (h - H_START_V) / BAR_W;
    case (idx)
      10'd0:   bar_colour = 12'hFFF;
      10'd1:   bar_colour = 12'hFF0;
      10'd2:   bar_colour = 12'h0FF;
      10'd3:   bar_colour = 12'h0F0;
      10'd4:   bar_colour = 12'hF0F;
      10'd5:   bar_colour = 12'hF00;
      10'd6:   bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  // Pixel source: built-in bars when test_mode is set, else the drawing controller.
  always_comb begin
    pix_src_s = rgb_in;
    if (test_mode) begin
      pix_src_s = bar_colour(h_r);
    end else begin
      pix_src_s = rgb_in;
    end
  end
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode;

  // Pixel source is always the drawing controller in this build.
  always_comb begin
    pix_src_s = rgb_in;
  end
`endif

  // Clock divider: pix_en pulses one clk after div reaches its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r    <= DIV_ZERO;
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= (div_r == DIV_LAST);
      if (div_r >= DIV_LAST) begin
        div_r <= DIV_ZERO;
      end else begin
        div_r <= div_r + DIV_ONE;
      end
    end
  end

  // Next raster position; out-of-range values fold back to zero instead of running on.
  always_comb begin
    h_next_s = h_r;
    v_next_s = v_r;
    if (pix_en_r) begin
      if (h_r >= H_LAST) begin
        h_next_s = 10'd0;
        if (v_r >= V_LAST) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = v_r + 10'd1;
        end
      end else begin
        h_next_s = h_r + 10'd1;
        v_next_s = v_r;
      end
    end else begin
      h_next_s = h_r;
      v_next_s = v_r;
    end
  end

  // Raster counters and the visible flag, which is derived from the next position
  // so it always matches the counts being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r      <= 10'd0;
      v_r      <= 10'd0;
      bright_r <= 1'b0;
    end else begin
      h_r      <= h_next_s;
      v_r      <= v_next_s;
      bright_r <= in_window(h_next_s, v_next_s);
    end
  end

  // Pin stage: syncs and colour for the current pixel land together one pixel later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= 12'h000;
    end else if (pix_en_r) begin
      hsync_r <= ~(h_r < H_SYNC_V);
      vsync_r <= ~(v_r < V_SYNC_V);
      rgb_r   <= bright_r ? pix_src_s : 12'h000;
    end else begin
      hsync_r <= hsync_r;
      vsync_r <= vsync_r;
      rgb_r   <= rgb_r;
    end
  end

  // End-of-frame tick: one clk after the last pixel of the last line is stepped.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pix_en_r && (h_r == H_LAST) && (v_r == V_LAST);
    end
  end

  assign pix_en     = pix_en_r;
  assign hCount     = h_r;
  assign vCount     = v_r;
  assign bright     = bright_r;
  assign hSync      = hsync_r;
  assign vSync      = vsync_r;
  assign rgb        = rgb_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. One instance uses the 640x480 defaults
// (pixel divider, line timing); a second, scaled-down instance makes whole
// frames, the visible window, mid-frame reset and the test pattern reachable
// in a short run. Scaled instance: PIX_DIV=2, 24 px/line (sync 3, visible
// 5..20), 10 lines/frame (sync 2, visible 3..8): 480 clk per frame.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_rst;
  logic [11:0] rgb_in, s_rgb_in;
  logic        test_mode, s_test_mode;

  logic        pix_en, bright, hSync, vSync, frame_tick;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb;

  logic        s_pix_en, s_bright, s_hSync, s_vSync, s_frame_tick;
  logic [9:0]  s_hCount, s_vCount;
  logic [11:0] s_rgb;

  int errors = 0;
  int checks = 0;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .test_mode(test_mode),
    .pix_en(pix_en), .hCount(hCount), .vCount(vCount), .bright(bright),
    .hSync(hSync), .vSync(vSync), .rgb(rgb), .frame_tick(frame_tick)
  );

  vga_timing_gen #(
    .PIX_DIV(2), .H_SYNC(3), .H_START(5), .H_END(20), .H_TOTAL(24),
    .V_SYNC(2), .V_START(3), .V_END(8), .V_TOTAL(10)
  ) dut_s (
    .clk(clk), .rst(s_rst), .rgb_in(s_rgb_in), .test_mode(s_test_mode),
    .pix_en(s_pix_en), .hCount(s_hCount), .vCount(s_vCount), .bright(s_bright),
    .hSync(s_hSync), .vSync(s_vSync), .rgb(s_rgb), .frame_tick(s_frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_pix_en"}, 32'(s_pix_en), 32'd0);
    check({tag, "_hCount"}, 32'(s_hCount), 32'd0);
    check({tag, "_vCount"}, 32'(s_vCount), 32'd0);
    check({tag, "_bright"}, 32'(s_bright), 32'd0);
    check({tag, "_hSync"}, 32'(s_hSync), 32'd1);
    check({tag, "_vSync"}, 32'(s_vSync), 32'd1);
    check({tag, "_rgb"}, 32'(s_rgb), 32'h000);
    check({tag, "_frame_tick"}, 32'(s_frame_tick), 32'd0);
  endtask

  // Advance the scaled instance until it is about to step pixel (h,v).
  task automatic wait_small_pix(input int h, input int v, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (s_pix_en && s_hCount == 10'(h) && s_vCount == 10'(v)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs_low, pix_cnt, rgb_nz0;
    int   ticks, tick1, tick2, ft_hi, vs_low, rgb_nz, rgb_bad;
    logic found;
    logic [11:0] exp_bar;

    // Step 1: hold reset with a bright colour on rgb_in; pins stay at reset values.
    rst = 1'b1; s_rst = 1'b1;
    rgb_in = 12'hF00; s_rgb_in = 12'hF00;
    test_mode = 1'b0; s_test_mode = 1'b0;
    repeat (3) tick();
    check("rst_pix_en", 32'(pix_en), 32'd0);
    check("rst_hCount", 32'(hCount), 32'd0);
    check("rst_vCount", 32'(vCount), 32'd0);
    check("rst_bright", 32'(bright), 32'd0);
    check("rst_hSync", 32'(hSync), 32'd1);
    check("rst_vSync", 32'(vSync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check_small_reset("s_rst");

    // Step 2: first 12 clk after release; pix_en on clk 4, 8, 12; hSync low from clk 5.
    rst = 1'b0;
    hs_low = 0; pix_cnt = 0; rgb_nz0 = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("start_pix_en_c%0d", i), 32'(pix_en), 32'((i % 4) == 0));
      check($sformatf("start_hCount_c%0d", i), 32'(hCount), 32'((i - 1) / 4));
      check($sformatf("start_hSync_c%0d", i), 32'(hSync), 32'(i < 5));
      check($sformatf("start_rgb_c%0d", i), 32'(rgb), 32'h000);
      if (!hSync) hs_low++;
      if (pix_en) pix_cnt++;
    end

    // Step 3: rest of line 0; hSync low for 96 pixels = 384 clk; line 0 is never visible.
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!hSync) hs_low++;
      if (pix_en) pix_cnt++;
      if (rgb != 12'h000) rgb_nz0++;
      if (pix_en && hCount == 10'd799) begin
        found = 1'b1;
        break;
      end
    end
    check("line_end_found", 32'(found), 32'd1);
    check("line_pix_count", 32'(pix_cnt), 32'd800);
    check("line_hsync_low_clk", 32'(hs_low), 32'd384);
    check("line0_rgb_nonzero_clk", 32'(rgb_nz0), 32'd0);
    check("line_end_vCount", 32'(vCount), 32'd0);
    tick();
    check("wrap_hCount", 32'(hCount), 32'd0);
    check("wrap_vCount", 32'(vCount), 32'd1);
    check("wrap_pix_en", 32'(pix_en), 32'd0);
    check("wrap_hSync", 32'(hSync), 32'd1);
    check("wrap_vSync", 32'(vSync), 32'd0);

    // Step 4: scaled instance, 1000 clk. Pixel n is stepped at clk 2n+3;
    // frame_tick at clk 481 and 961; frame 2 occupies clk 481..960.
    s_rst = 1'b0;
    ticks = 0; tick1 = 0; tick2 = 0; ft_hi = 0; vs_low = 0; rgb_nz = 0; rgb_bad = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (s_frame_tick) begin
        ft_hi++;
        if (ticks == 0) tick1 = k;
        else if (ticks == 1) tick2 = k;
        ticks++;
        check($sformatf("tick_hCount_c%0d", k), 32'(s_hCount), 32'd0);
        check($sformatf("tick_vCount_c%0d", k), 32'(s_vCount), 32'd0);
      end
      if (k >= 481 && k <= 960) begin
        if (!s_vSync) vs_low++;
        if (s_rgb != 12'h000) begin
          rgb_nz++;
          if (s_rgb != 12'hF00) rgb_bad++;
        end
      end
      if (k == 482) begin
        check("f2_pre_hSync", 32'(s_hSync), 32'd1);
        check("f2_pre_vSync", 32'(s_vSync), 32'd1);
      end
      if (k == 483) begin
        check("f2_first_hSync", 32'(s_hSync), 32'd0);
        check("f2_first_vSync", 32'(s_vSync), 32'd0);
      end
      if (k == 636) check("f2_before_visible_rgb", 32'(s_rgb), 32'h000);
      if (k == 637) check("f2_first_visible_rgb", 32'(s_rgb), 32'hF00);
    end
    check("frame_tick_count", 32'(ticks), 32'd2);
    check("frame_tick_high_clk", 32'(ft_hi), 32'd2);
    check("frame_tick_first_clk", 32'(tick1), 32'd481);
    check("frame_tick_second_clk", 32'(tick2), 32'd961);
    check("frame_vsync_low_clk", 32'(vs_low), 32'd96);
    check("frame_rgb_nonzero_clk", 32'(rgb_nz), 32'd192);
    check("frame_rgb_wrong_value", 32'(rgb_bad), 32'd0);

    // Step 5: reset the scaled instance mid-frame at (12,6), inside the visible window.
    wait_small_pix(12, 6, "mid_frame");
    check("mid_frame_rgb", 32'(s_rgb), 32'hF00);
    s_rst = 1'b1;
    tick();
    check_small_reset("midrst");
    s_rst = 1'b0;
    tick();
    check("restart_c1_pix_en", 32'(s_pix_en), 32'd0);
    check("restart_c1_hCount", 32'(s_hCount), 32'd0);
    tick();
    check("restart_c2_pix_en", 32'(s_pix_en), 32'd1);
    check("restart_c2_hCount", 32'(s_hCount), 32'd0);
    tick();
    check("restart_c3_pix_en", 32'(s_pix_en), 32'd0);
    check("restart_c3_hCount", 32'(s_hCount), 32'd1);
    check("restart_c3_frame_tick", 32'(s_frame_tick), 32'd0);

    // Step 6: test_mode on line 4; bars are 2 px wide from column 5.
    s_test_mode = 1'b1;
    s_rgb_in = 12'h0F0;
`ifdef TEST_PATTERN_EN
    exp_bar = 12'hFFF;
`else
    exp_bar = 12'h0F0;
`endif
    wait_small_pix(5, 4, "bar_h5");
    tick();
    check("bar_h5_rgb", 32'(s_rgb), 32'(exp_bar));
`ifdef TEST_PATTERN_EN
    exp_bar = 12'hF0F;
`endif
    wait_small_pix(13, 4, "bar_h13");
    tick();
    check("bar_h13_rgb", 32'(s_rgb), 32'(exp_bar));
`ifdef TEST_PATTERN_EN
    exp_bar = 12'hF00;
`endif
    wait_small_pix(15, 4, "bar_h15");
    tick();
    check("bar_h15_rgb", 32'(s_rgb), 32'(exp_bar));
`ifdef TEST_PATTERN_EN
    exp_bar = 12'h000;
`endif
    wait_small_pix(20, 4, "bar_h20");
    tick();
    check("bar_h20_rgb", 32'(s_rgb), 32'(exp_bar));
    check("bar_hSync", 32'(s_hSync), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
